// File: rtl/pixel_fb_pkg.sv
// Shared definitions for the pixel shadow framebuffer.
//   XSCREEN_DEF / YSCREEN_DEF : default screen size in pixels
//   FB_ADDR_W                 : framebuffer word address width
//   COLOUR_W                  : bits per pixel
//   state_t                   : probe FSM state encoding
// Optional feature macro: PIXEL_SHADOW_CLEAR_EN adds the CLEAR state.
package pixel_fb_pkg;

  localparam int XSCREEN_DEF = 160;
  localparam int YSCREEN_DEF = 120;
  localparam int FB_ADDR_W   = 15;
  localparam int COLOUR_W    = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3
`ifdef PIXEL_SHADOW_CLEAR_EN
    ,
    ST_CLEAR = 3'd4
`endif
  } state_t;

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port framebuffer RAM.
//   clk     : clock, rising edge
//   we      : write enable
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address
//   rd_data : registered read data, one cycle after rd_addr is sampled;
//             a same-address write in that cycle is not visible (old data).
// Contents start at INIT when the device is configured.
module fb_ram #(
  parameter int              ADDR_W = 15,
  parameter int              DATA_W = 3,
  parameter int              DEPTH  = 19200,
  parameter logic [DATA_W-1:0] INIT = '0
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH] = '{default: INIT};

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pixel_shadow_fb.sv
// Pixel shadow framebuffer with tile probe.
// Keeps a copy of every plotted pixel and, on request, scans a TILE_W x TILE_H
// tile for the first pixel that differs from the background colour.
//   CLOCK_50          : clock, rising edge
//   Reset             : synchronous active-high reset
//   plot, x, y, colour: pixel write (off-screen writes are dropped)
//   start, px, py     : probe request with tile origin
//   busy              : high whenever the FSM is not idle
//   done              : one-cycle pulse when a probe completes
//   hit, hit_colour   : probe result, held until the next accepted start
// Optional feature macro: PIXEL_SHADOW_CLEAR_EN -- Reset sweeps the RAM to
// BG_COLOUR in a CLEAR state, blocking plot and start while it runs.
module pixel_shadow_fb
  import pixel_fb_pkg::*;
#(
  parameter int         XSCREEN   = XSCREEN_DEF,
  parameter int         YSCREEN   = YSCREEN_DEF,
  parameter int         TILE_W    = 10,
  parameter int         TILE_H    = 10,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       CLOCK_50,
  input  logic       Reset,
  input  logic       plot,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       start,
  input  logic [7:0] px,
  input  logic [6:0] py,
  output logic       busy,
  output logic       done,
  output logic       hit,
  output logic [2:0] hit_colour
);

  localparam int DEPTH = XSCREEN * YSCREEN;
  localparam int XC_W  = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int YC_W  = (TILE_H > 1) ? $clog2(TILE_H) : 1;
  localparam logic [8:0]      X_LIM   = 9'(XSCREEN);
  localparam logic [7:0]      Y_LIM   = 8'(YSCREEN);
  localparam logic [XC_W-1:0] XC_LAST = XC_W'(TILE_W - 1);
  localparam logic [YC_W-1:0] YC_LAST = YC_W'(TILE_H - 1);

  // Row-major address; with XSCREEN=160 the multiply reduces to (y<<7)+(y<<5)+x.
  function automatic logic [FB_ADDR_W-1:0] pix_addr(input logic [8:0] cx,
                                                     input logic [7:0] cy);
    return FB_ADDR_W'(cy) * FB_ADDR_W'(XSCREEN) + FB_ADDR_W'(cx);
  endfunction

  state_t                state;
  logic [7:0]            px_q;
  logic [6:0]            py_q;
  logic [XC_W-1:0]       xc;
  logic [YC_W-1:0]       yc;
  logic                  rvld_p1;
  logic [8:0]            cx;
  logic [7:0]            cy;
  logic                  coord_ok;
  logic                  plot_ok;
  logic                  we;
  logic [FB_ADDR_W-1:0]  wr_addr;
  logic [COLOUR_W-1:0]   wr_data;
  logic [FB_ADDR_W-1:0]  rd_addr;
  logic [COLOUR_W-1:0]   rd_data;
`ifdef PIXEL_SHADOW_CLEAR_EN
  localparam logic [FB_ADDR_W-1:0] CLR_LAST = FB_ADDR_W'(DEPTH - 1);
  logic [FB_ADDR_W-1:0]  clr_addr;
  logic                  clearing;
`endif

  // Probe coordinates are one bit wider than the screen fields so a tile
  // hanging past the right/bottom edge is seen as off-screen, never wrapped.
  assign cx       = {1'b0, px_q} + 9'(xc);
  assign cy       = {1'b0, py_q} + 8'(yc);
  assign coord_ok = (cx < X_LIM) && (cy < Y_LIM);
  assign rd_addr  = coord_ok ? pix_addr(cx, cy) : '0;
  assign plot_ok  = plot && ({1'b0, x} < X_LIM) && ({1'b0, y} < Y_LIM);

`ifdef PIXEL_SHADOW_CLEAR_EN
  assign clearing = (state == ST_CLEAR);
  assign we       = clearing || (plot_ok && !Reset);
  assign wr_addr  = clearing ? clr_addr : pix_addr({1'b0, x}, {1'b0, y});
  assign wr_data  = clearing ? BG_COLOUR : colour;
`else
  assign we       = plot_ok;
  assign wr_addr  = pix_addr({1'b0, x}, {1'b0, y});
  assign wr_data  = colour;
`endif

  fb_ram #(
    .ADDR_W (FB_ADDR_W),
    .DATA_W (COLOUR_W),
    .DEPTH  (DEPTH),
    .INIT   (BG_COLOUR)
  ) u_ram (
    .clk     (CLOCK_50),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
`ifdef PIXEL_SHADOW_CLEAR_EN
      state    <= ST_CLEAR;
      busy     <= 1'b1;
      clr_addr <= '0;
`else
      state    <= ST_IDLE;
      busy     <= 1'b0;
`endif
      done       <= 1'b0;
      hit        <= 1'b0;
      hit_colour <= BG_COLOUR;
      xc         <= '0;
      yc         <= '0;
      rvld_p1    <= 1'b0;
    end else begin
      // Stage p0 -> p1: read issued this cycle returns next cycle
      done    <= 1'b0;
      rvld_p1 <= (state == ST_SCAN) && coord_ok;
      // Stage p1: evaluate returned pixel; only the first match is kept
      if (rvld_p1 && !hit && (rd_data != BG_COLOUR)) begin
        hit        <= 1'b1;
        hit_colour <= rd_data;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            px_q       <= px;
            py_q       <= py;
            hit        <= 1'b0;
            hit_colour <= BG_COLOUR;
            xc         <= '0;
            yc         <= '0;
            state      <= ST_SCAN;
            busy       <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (xc == XC_LAST) begin
            xc <= '0;
            if (yc == YC_LAST) begin
              yc    <= '0;
              state <= ST_DRAIN;
            end else begin
              yc <= yc + 1'b1;
            end
          end else begin
            xc <= xc + 1'b1;
          end
        end
        ST_DRAIN: begin
          state <= ST_DONE;
          done  <= 1'b1;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
`ifdef PIXEL_SHADOW_CLEAR_EN
        ST_CLEAR: begin
          if (clr_addr == CLR_LAST) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
`endif
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
